note_word_sequencer: RTL and testbench

//   Upstream stage of the word classifier. Collects one word of musical notes
//   ({Tom, Nota}) from the key interface into a small buffer, then replays it to
//   the classifier one note per clock with Ready high, followed by the 3'b000

---
 rtl/note_word_sequencer_if.sv | 29 ++
 rtl/note_word_sequencer.sv | 111 +++++++++++
 tb/tb_note_word_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/note_word_sequencer_if.sv
// Key-side and classifier-side signals of the note word sequencer.
// The sequencer attaches through slave; the key/classifier side attaches through master.
interface note_word_sequencer_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_tom;
    logic [2:0]    in_nota;
    logic          in_ready;
    logic          Ready;
    logic          Tom;
    logic [2:0]    Nota;
    logic          End;
    logic [LW-1:0] word_len;
    logic          overflow;
    logic          err;

    modport master (
        output in_valid, in_tom, in_nota, End,
        input  in_ready, Ready, Tom, Nota, word_len, overflow, err
    );

    modport slave (
        input  in_valid, in_tom, in_nota, End,
        output in_ready, Ready, Tom, Nota, word_len, overflow, err
    );
endinterface

// File: rtl/note_word_sequencer.sv
// Buffers one word of {Tom, Nota} keys, then replays it to the classifier one note
// per clock followed by a held 3'b000 terminator until End (or a timeout) is seen.
module note_word_sequencer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  Reset,
    note_word_sequencer_if.slave  bus,
    output logic [1:0]            state_dbg
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PLAY    = 2'd1,
        TERM    = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    buffer [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [TW-1:0] tcount;
    logic          accept;
    logic          write_en;

    // Handshake: a key transfers on any rising edge where in_valid and in_ready are
    // both high; in_ready is high only while collecting. Ready has no back-pressure:
    // the classifier must take one note per cycle while Ready is high.
    assign accept    = bus.in_valid & bus.in_ready;
    assign write_en  = accept && (bus.in_nota != 3'b000) && (bus.word_len < LW'(DEPTH));
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (write_en) begin
            buffer[wr_ptr] <= {bus.in_tom, bus.in_nota};
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state        <= COLLECT;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            tcount       <= '0;
            bus.word_len <= '0;
            bus.in_ready <= 1'b1;
            bus.Ready    <= 1'b0;
            bus.Tom      <= 1'b0;
            bus.Nota     <= 3'b000;
            bus.overflow <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (bus.in_nota != 3'b000) begin
                            if (bus.word_len < LW'(DEPTH)) begin
                                wr_ptr       <= wr_ptr + 1'b1;
                                bus.word_len <= bus.word_len + 1'b1;
                            end else begin
                                bus.overflow <= 1'b1;
                            end
                        end else if (bus.word_len != '0) begin
                            // Note 0 goes out on this edge so replay starts the next cycle.
                            state                <= PLAY;
                            bus.in_ready         <= 1'b0;
                            bus.Ready            <= 1'b1;
                            {bus.Tom, bus.Nota}  <= buffer[0];
                            rd_ptr               <= LW'(1);
                        end
                    end
                end
                PLAY: begin
                    if (rd_ptr == bus.word_len) begin
                        state    <= TERM;
                        bus.Tom  <= 1'b0;
                        bus.Nota <= 3'b000;
                        tcount   <= '0;
                    end else begin
                        {bus.Tom, bus.Nota} <= buffer[rd_ptr[AW-1:0]];
                        rd_ptr              <= rd_ptr + 1'b1;
                    end
                end
                TERM: begin
                    if (bus.End || (tcount == TW'(TIMEOUT - 1))) begin
                        bus.err      <= ~bus.End;
                        state        <= COLLECT;
                        bus.in_ready <= 1'b1;
                        bus.Ready    <= 1'b0;
                        bus.Tom      <= 1'b0;
                        bus.Nota     <= 3'b000;
                        wr_ptr       <= '0;
                        rd_ptr       <= '0;
                        bus.word_len <= '0;
                        bus.overflow <= 1'b0;
                    end else begin
                        tcount <= tcount + 1'b1;
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_note_word_sequencer.sv
// Self-checking bench for note_word_sequencer: table-driven words, hand-written
// corner sequences, and a replay scoreboard fed from the key driver.
module tb_note_word_sequencer;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [47:0] notes;
        int          n;
        logic        term_tom;
        logic [3:0]  exp_len;
        logic        exp_ovf;
    } word_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;

    note_word_sequencer_if #(.DEPTH(DEPTH)) bus();

    note_word_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .Reset     (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    logic [3:0] exp_q[$];
    int         n_cmp   = 0;
    int         n_err   = 0;
    logic       in_term = 1'b0;
    word_vec_t  vecs [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Replay monitor: every note while Ready is high, plus the first terminator cycle.
    always @(negedge clk) begin
        if (rst) begin
            in_term <= 1'b0;
        end else if (bus.Ready) begin
            if (!in_term) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_note: got %0h expected none at %0t",
                             {bus.Tom, bus.Nota}, $time);
                end else begin
                    check("replay_note", 32'({bus.Tom, bus.Nota}), 32'(exp_q.pop_front()));
                end
                if (bus.Nota == 3'b000) in_term <= 1'b1;
            end
        end else begin
            in_term <= 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the key is accepted.
    task automatic send_key(input logic tom, input logic [2:0] nota);
        bus.in_valid = 1'b1;
        bus.in_tom   = tom;
        bus.in_nota  = nota;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_tom   = 1'b0;
        bus.in_nota  = 3'b000;
    endtask

    task automatic play_word(input logic [47:0] notes, input int n, input logic term_tom,
                             input logic [3:0] exp_len, input logic exp_ovf, input bit noise);
        int stored = 0;
        int cyc;
        for (int i = 0; i < n; i++) begin
            if (stored < DEPTH) begin
                exp_q.push_back(notes[i*4 +: 4]);
                stored++;
            end
            send_key(notes[i*4+3], notes[i*4 +: 3]);
        end
        exp_q.push_back(4'h0);
        send_key(term_tom, 3'b000);
        for (cyc = 1; cyc <= DEPTH + 4; cyc++) begin
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_tom   = 1'b1;
                bus.in_nota  = 3'b111;
            end
            @(negedge clk);
            if (cyc == 1) check("in_ready_play", 32'(bus.in_ready), 32'd0);
            #1;
            if (exp_q.size() == 0) break;
        end
        check("replay_cycles", 32'(cyc), 32'(stored + 1));
        exp_q.delete();
        bus.in_valid = 1'b0;
        bus.in_tom   = 1'b0;
        bus.in_nota  = 3'b000;
        check("term_state", 32'(state_dbg), 32'd2);
        check("term_ready", 32'(bus.Ready), 32'd1);
        check("word_len", 32'(bus.word_len), 32'(exp_len));
        check("overflow", 32'(bus.overflow), 32'(exp_ovf));
        bus.End = 1'b1;
        @(posedge clk);
        #1;
        bus.End = 1'b0;
        @(negedge clk);
        check("end_ready", 32'(bus.Ready), 32'd0);
        check("end_in_ready", 32'(bus.in_ready), 32'd1);
        check("end_word_len", 32'(bus.word_len), 32'd0);
        check("end_overflow", 32'(bus.overflow), 32'd0);
        check("end_note", 32'({bus.Tom, bus.Nota}), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   err_cnt;
        int   err_at;
        int   n;
        logic [47:0] rnd;

        vecs[0] = '{notes: 48'h43,       n: 2, term_tom: 1'b0, exp_len: 4'd2, exp_ovf: 1'b0};
        vecs[1] = '{notes: 48'h555555555, n: 9, term_tom: 1'b1, exp_len: 4'd8, exp_ovf: 1'b1};
        vecs[2] = '{notes: 48'h1F6D4B29, n: 8, term_tom: 1'b0, exp_len: 4'd8, exp_ovf: 1'b0};
        vecs[3] = '{notes: 48'hF,        n: 1, term_tom: 1'b1, exp_len: 4'd1, exp_ovf: 1'b0};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_tom   = 1'b0;
        bus.in_nota  = 3'b000;
        bus.End      = 1'b0;
        #7;
        check("rst_ready", 32'(bus.Ready), 32'd0);
        check("rst_note", 32'({bus.Tom, bus.Nota}), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_word_len", 32'(bus.word_len), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            play_word(vecs[k].notes, vecs[k].n, vecs[k].term_tom, vecs[k].exp_len,
                      vecs[k].exp_ovf, 1'b0);
        end

        // Terminator into an empty buffer is ignored.
        send_key(1'b1, 3'b000);
        @(negedge clk);
        check("empty_ready", 32'(bus.Ready), 32'd0);
        check("empty_in_ready", 32'(bus.in_ready), 32'd1);
        check("empty_word_len", 32'(bus.word_len), 32'd0);
        check("empty_state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;

        // Keys offered during PLAY/TERM must not reach the buffer.
        play_word(48'h72A, 3, 1'b0, 4'd3, 1'b0, 1'b1);
        play_word(48'h61C, 3, 1'b0, 4'd3, 1'b0, 1'b0);

        // End never arrives: err pulses once, 16 cycles after entering TERM.
        exp_q.push_back(4'h3);
        exp_q.push_back(4'h0);
        send_key(1'b0, 3'b011);
        send_key(1'b0, 3'b000);
        err_cnt = 0;
        err_at  = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.err) begin
                err_cnt++;
                if (err_at < 0) err_at = k;
            end
        end
        check("timeout_err_count", 32'(err_cnt), 32'd1);
        check("timeout_err_cycle", 32'(err_at), 32'd17);
        check("timeout_ready", 32'(bus.Ready), 32'd0);
        check("timeout_in_ready", 32'(bus.in_ready), 32'd1);
        check("timeout_word_len", 32'(bus.word_len), 32'd0);
        check("timeout_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;

        // Reset during replay of a 5-note word.
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back({1'(i % 2), 3'(i)});
            send_key(1'(i % 2), 3'(i));
        end
        exp_q.push_back(4'h0);
        send_key(1'b0, 3'b000);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(bus.Ready), 32'd0);
        check("midrst_note", 32'({bus.Tom, bus.Nota}), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_word_len", 32'(bus.word_len), 32'd0);
        check("midrst_state", 32'(state_dbg), 32'd0);
        exp_q.delete();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        play_word(48'hE9B, 3, 1'b0, 4'd3, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            n   = $urandom_range(1, 10);
            rnd = '0;
            for (int i = 0; i < n; i++) begin
                rnd[i*4 +: 4] = {1'($urandom_range(0, 1)), 3'($urandom_range(1, 7))};
            end
            play_word(rnd, n, 1'($urandom_range(0, 1)), 4'((n > DEPTH) ? DEPTH : n),
                      (n > DEPTH), 1'b0);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
